// File: rtl/irq_vector_ctrl_if.sv
// Core-side interrupt handshake bundle: request/vector/id/service status
// toward the core, acknowledge and end-of-interrupt back from it.
interface irq_vector_ctrl_if #(
   parameter int NUM_SRC = 8,
   parameter int ADDR_W  = 32
);
   localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic              irq;
   logic [ADDR_W-1:0] irq_addr;
   logic [ID_W-1:0]   active_id;
   logic              in_service;
   logic              irq_ack;
   logic              eoi;

   // Controller side drives the request, core side answers with ack/eoi.
   modport master (
      output irq, irq_addr, active_id, in_service,
      input  irq_ack, eoi
   );

   modport slave (
      input  irq, irq_addr, active_id, in_service,
      output irq_ack, eoi
   );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Multi-source vectored interrupt controller in front of the MIPS core.
// Fixed priority (lowest index wins), per-source edge/level mode and enable,
// sticky overrun flags, and a request -> ack -> eoi service handshake.
module irq_vector_ctrl #(
   parameter int                NUM_SRC    = 8,
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 'h20,
   parameter logic [ADDR_W-1:0] VEC_STRIDE = 'h10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src,
   input  logic [NUM_SRC-1:0] src_en,
   input  logic [NUM_SRC-1:0] src_edge,
   output logic [NUM_SRC-1:0] overrun,
   input  logic [NUM_SRC-1:0] ovr_clr,
   irq_vector_ctrl_if.master  bus
);
   localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t              state_reg, state_next;
   logic [NUM_SRC-1:0]  src_q_reg;
   logic [NUM_SRC-1:0]  pend_reg, pend_next;
   logic [NUM_SRC-1:0]  overrun_reg, overrun_next;
   logic [ID_W-1:0]     id_reg;
   logic [ADDR_W-1:0]   addr_reg;

   logic [NUM_SRC-1:0]  rise, clr, pend, req, ovr_set;
   logic [ID_W-1:0]     sel_id;
   logic [ADDR_W-1:0]   vec_addr;
   logic                req_any;
   logic                ack_take;

   // An ack only counts while a request is actually outstanding.
   assign ack_take = (state_reg == REQ) && bus.irq_ack;

   // Per-source pending/overrun bookkeeping. Level sources bypass the
   // pending latch entirely; a new edge always beats the ack-driven clear.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign rise[gi]         = src_edge[gi] & src[gi] & ~src_q_reg[gi];
         assign clr[gi]          = ack_take && (id_reg == ID_W'(gi));
         assign pend[gi]         = src_edge[gi] ? pend_reg[gi] : src[gi];
         assign pend_next[gi]    = rise[gi] | (pend_reg[gi] & ~clr[gi]);
         assign ovr_set[gi]      = rise[gi] & pend_reg[gi] & ~clr[gi];
         assign overrun_next[gi] = ovr_set[gi] | (overrun_reg[gi] & ~ovr_clr[gi]);
      end
   endgenerate

   assign req     = pend & src_en;
   assign req_any = |req;

   // Lowest-index requester wins; vector is base plus id times stride.
   always_comb begin
      sel_id = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) sel_id = ID_W'(i);
      end
      vec_addr = VEC_BASE + ADDR_W'(sel_id) * VEC_STRIDE;
   end

   // Edge history, pending edges and sticky overrun flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q_reg   <= '0;
         pend_reg    <= '0;
         overrun_reg <= '0;
      end else begin
         src_q_reg   <= src;
         pend_reg    <= pend_next;
         overrun_reg <= overrun_next;
      end
   end

   // Capture the winner when leaving IDLE; held through REQ and SERVICE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_reg   <= '0;
         addr_reg <= '0;
      end else if (state_reg == IDLE && req_any) begin
         id_reg   <= sel_id;
         addr_reg <= vec_addr;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // FSM next-state: no pre-emption, no nesting; stray ack/eoi ignored.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_any)     state_next = REQ;
         REQ:     if (bus.irq_ack) state_next = SERVICE;
         SERVICE: if (bus.eoi)     state_next = IDLE;
         default:                  state_next = IDLE;
      endcase
   end

   // FSM outputs: decoded straight from the registered state.
   always_comb begin
      bus.irq        = (state_reg == REQ);
      bus.in_service = (state_reg == SERVICE);
   end

   assign bus.irq_addr  = addr_reg;
   assign bus.active_id = id_reg;
   assign overrun       = overrun_reg;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed bench for irq_vector_ctrl: single source, priority, level/enable,
// overrun, async reset mid-request, ignored and combined handshakes.
module tb_irq_vector_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] src, src_en, src_edge, ovr_clr, overrun;
   int         checks = 0;
   int         failures = 0;

   irq_vector_ctrl_if #(.NUM_SRC(8), .ADDR_W(32)) bus_if ();

   irq_vector_ctrl #(
      .NUM_SRC(8), .ADDR_W(32), .VEC_BASE(32'h20), .VEC_STRIDE(32'h10)
   ) dut (
      .clk(clk), .rst(rst), .src(src), .src_en(src_en), .src_edge(src_edge),
      .overrun(overrun), .ovr_clr(ovr_clr), .bus(bus_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
         $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check the full core-facing status in one line.
   task automatic check_bus(input string tag, input logic irq, input logic [31:0] addr,
                            input logic [2:0] id, input logic insvc);
      check({tag, ".irq"},  64'(bus_if.irq),        64'(irq));
      check({tag, ".addr"}, 64'(bus_if.irq_addr),   64'(addr));
      check({tag, ".id"},   64'(bus_if.active_id),  64'(id));
      check({tag, ".isvc"}, 64'(bus_if.in_service), 64'(insvc));
   endtask

   task automatic pulse_ack();
      bus_if.irq_ack = 1'b1; tick(); bus_if.irq_ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      bus_if.eoi = 1'b1; tick(); bus_if.eoi = 1'b0;
   endtask

   initial begin
      rst = 1'b0; src = '0; src_en = '0; src_edge = '0; ovr_clr = '0;
      bus_if.irq_ack = 1'b0; bus_if.eoi = 1'b0;
      tick(); tick();
      check_bus("reset", 1'b0, 32'h0, 3'd0, 1'b0);
      check("reset.ovr", 64'(overrun), 64'h0);
      rst = 1'b1; src_edge = 8'hFF; src_en = 8'hFF;
      tick();

      // Single source 3: irq two cycles after the edge.
      src = 8'h08; tick(); src = 8'h00;
      check("s3.lat1.irq", 64'(bus_if.irq), 64'h0);
      tick();
      check_bus("s3.req", 1'b1, 32'h50, 3'd3, 1'b0);
      repeat (5) tick();
      check_bus("s3.hold", 1'b1, 32'h50, 3'd3, 1'b0);
      pulse_ack();
      check_bus("s3.svc", 1'b0, 32'h50, 3'd3, 1'b1);
      pulse_eoi();
      check_bus("s3.idle", 1'b0, 32'h50, 3'd3, 1'b0);
      tick(); tick();
      check("s3.noreq.irq", 64'(bus_if.irq), 64'h0);

      // eoi in IDLE is ignored.
      pulse_eoi();
      check_bus("eoi_idle", 1'b0, 32'h50, 3'd3, 1'b0);

      // Priority: 5 and 2 together, 2 first, 5 two cycles after eoi.
      src = 8'h24; tick(); src = 8'h00; tick();
      check_bus("pri.first", 1'b1, 32'h40, 3'd2, 1'b0);
      pulse_ack();
      check_bus("pri.svc", 1'b0, 32'h40, 3'd2, 1'b1);
      // irq_ack in SERVICE is ignored.
      pulse_ack();
      check_bus("ack_svc", 1'b0, 32'h40, 3'd2, 1'b1);
      pulse_eoi();
      check("pri.gap.irq", 64'(bus_if.irq), 64'h0);
      tick();
      check_bus("pri.second", 1'b1, 32'h70, 3'd5, 1'b0);
      pulse_ack(); pulse_eoi(); tick();
      check("pri.done.irq", 64'(bus_if.irq), 64'h0);

      // Level source 1, gated by enable, re-requests while held high.
      src_edge = 8'hFD; src_en = 8'hFD; src = 8'h02;
      tick(); tick();
      check("lvl.dis.irq", 64'(bus_if.irq), 64'h0);
      src_en = 8'hFF; tick();
      check_bus("lvl.req", 1'b1, 32'h30, 3'd1, 1'b0);
      src_en = 8'hFD; tick();
      check_bus("lvl.nowd", 1'b1, 32'h30, 3'd1, 1'b0);
      src_en = 8'hFF;
      pulse_ack(); pulse_eoi(); tick();
      check_bus("lvl.rereq", 1'b1, 32'h30, 3'd1, 1'b0);
      src = 8'h00;
      pulse_ack(); pulse_eoi(); tick(); tick();
      check("lvl.off.irq", 64'(bus_if.irq), 64'h0);
      src_edge = 8'hFF;

      // Overrun: two edges on 4 while servicing 0, one service of 4.
      src = 8'h01; tick(); src = 8'h00; tick();
      check_bus("ovr.req0", 1'b1, 32'h20, 3'd0, 1'b0);
      pulse_ack();
      src = 8'h10; tick(); src = 8'h00; tick();
      check("ovr.none", 64'(overrun), 64'h0);
      src = 8'h10; tick(); src = 8'h00; tick();
      check("ovr.set", 64'(overrun), 64'h10);
      pulse_eoi(); tick();
      check_bus("ovr.req4", 1'b1, 32'h60, 3'd4, 1'b0);
      pulse_ack(); pulse_eoi(); tick(); tick();
      check("ovr.single.irq", 64'(bus_if.irq), 64'h0);
      check("ovr.sticky", 64'(overrun), 64'h10);
      ovr_clr = 8'h10; tick(); ovr_clr = 8'h00;
      check("ovr.clr", 64'(overrun), 64'h0);

      // Edge on the acked source in the ack cycle: pend survives, no overrun.
      src = 8'h08; tick(); src = 8'h00; tick();
      check_bus("setclr.req", 1'b1, 32'h50, 3'd3, 1'b0);
      src = 8'h08; bus_if.irq_ack = 1'b1; tick();
      bus_if.irq_ack = 1'b0; src = 8'h00;
      check("setclr.ovr", 64'(overrun), 64'h0);
      pulse_eoi(); tick();
      check_bus("setclr.rereq", 1'b1, 32'h50, 3'd3, 1'b0);
      pulse_ack(); pulse_eoi(); tick();

      // Async reset mid-REQ, no clock edge in between.
      src = 8'h40; tick(); src = 8'h00; tick();
      check_bus("ar.req", 1'b1, 32'h80, 3'd6, 1'b0);
      #2 rst = 1'b0;
      #1;
      check_bus("ar.async", 1'b0, 32'h0, 3'd0, 1'b0);
      tick(); rst = 1'b1; tick(); tick();
      check_bus("ar.nostale", 1'b0, 32'h0, 3'd0, 1'b0);

      // ack and eoi together in REQ: ack wins, a separate eoi ends service.
      src = 8'h80; tick(); src = 8'h00; tick();
      check_bus("ae.req", 1'b1, 32'h90, 3'd7, 1'b0);
      bus_if.irq_ack = 1'b1; bus_if.eoi = 1'b1; tick();
      bus_if.irq_ack = 1'b0; bus_if.eoi = 1'b0;
      check_bus("ae.svc", 1'b0, 32'h90, 3'd7, 1'b1);
      tick();
      check("ae.still.isvc", 64'(bus_if.in_service), 64'h1);
      pulse_eoi();
      check_bus("ae.idle", 1'b0, 32'h90, 3'd7, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
